// File: rtl/dm_arbiter.sv
// dm_arbiter: owner-sticky, burst-bounded arbiter sharing the data memory between CPU and DMA
module dm_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int DEPTH     = 1024,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c0_req,
    input  logic          c0_we,
    input  logic [AW-1:0] c0_addr,
    input  logic [DW-1:0] c0_wdata,
    input  logic          c1_req,
    input  logic          c1_we,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c1_wdata,
    output logic          c0_gnt,
    output logic          c1_gnt,
    output logic          c0_rvalid,
    output logic          c1_rvalid,
    output logic [DW-1:0] rdata,
    output logic          rd_err,
    output logic [AW-1:0] dm_addr,
    output logic          dm_re,
    output logic          dm_we,
    output logic [DW-1:0] dm_wrt_data,
    input  logic [DW-1:0] dm_rd_data
);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

    logic          owner;
    logic [CW-1:0] beat_cnt;
    logic          any_req;
    logic          pick;
    logic          gnt;
    logic          sel_we;
    logic          in_range;
    logic          rd_go;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // pick the winner (owner keeps the grant until its burst budget is spent) and drive the memory
    always_comb begin
        any_req     = c0_req | c1_req;
        pick        = (c0_req & c1_req) ? ((beat_cnt < BMAX) ? owner : ~owner) : c1_req;
        c0_gnt      = rst_n & any_req & ~pick;
        c1_gnt      = rst_n & any_req & pick;
        gnt         = c0_gnt | c1_gnt;
        sel_we      = pick ? c1_we : c0_we;
        sel_addr    = pick ? c1_addr : c0_addr;
        sel_wdata   = pick ? c1_wdata : c0_wdata;
        in_range    = int'(sel_addr) < DEPTH;
        dm_re       = gnt & in_range & ~sel_we;
        dm_we       = gnt & in_range & sel_we;
        dm_addr     = gnt ? sel_addr : '0;
        dm_wrt_data = gnt ? sel_wdata : '0;
        rd_go       = gnt & ~sel_we;
    end

    // track the last granted client and how long its current burst has run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= 1'b0;
            beat_cnt <= '0;
        end else if (!any_req) begin
            beat_cnt <= '0;
        end else if (pick == owner) begin
            beat_cnt <= (beat_cnt == BMAX) ? BMAX : beat_cnt + 1'b1;
        end else begin
            owner    <= pick;
            beat_cnt <= CW'(1);
        end
    end

    // capture the granted read at the end of its cycle and flag it to the requesting client
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0_rvalid <= 1'b0;
            c1_rvalid <= 1'b0;
            rd_err    <= 1'b0;
            rdata     <= '0;
        end else begin
            c0_rvalid <= rd_go & ~pick;
            c1_rvalid <= rd_go & pick;
            rd_err    <= rd_go & ~in_range;
            if (rd_go) rdata <= in_range ? dm_rd_data : '0;
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed and randomized checks of dm_arbiter against a behavioural reference model
module tb_dm_arbiter;
    localparam int AW = 16, DW = 16, DEPTH = 1024, BM = 4;
    localparam int IW = $clog2(DEPTH);

    logic clk = 1'b0, rst_n = 1'b0;
    logic c0_req = 1'b0, c1_req = 1'b0, c0_we = 1'b0, c1_we = 1'b0;
    logic [AW-1:0] c0_addr = '0, c1_addr = '0;
    logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
    logic c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, rd_err, dm_re, dm_we;
    logic [DW-1:0] rdata, dm_wrt_data;
    logic [DW-1:0] dm_rd_data = '0;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] mem [DEPTH];

    int checks = 0, errors = 0;
    int m_owner, m_beats;
    bit e_rv0, e_rv1, e_err;
    logic [DW-1:0] e_rdata;
    logic [DW-1:0] shadow [DEPTH];

    always #5 clk = ~clk;

    dm_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .BURST_MAX(BM)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
        .rdata(rdata), .rd_err(rd_err), .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we),
        .dm_wrt_data(dm_wrt_data), .dm_rd_data(dm_rd_data)
    );

    // single-ported memory: accesses complete on the falling edge of the access cycle
    always @(negedge clk) begin
        if (dm_we) mem[dm_addr[IW-1:0]] <= dm_wrt_data;
        if (dm_re) dm_rd_data <= mem[dm_addr[IW-1:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_beats = 0;
        e_rv0 = 0;
        e_rv1 = 0;
        e_err = 0;
        e_rdata = '0;
    endtask

    // one clock cycle: drive requests, check combinational outputs, clock, check the read return
    task automatic cyc(input bit r0, input bit w0, input logic [15:0] a0, input logic [15:0] d0,
                       input bit r1, input bit w1, input logic [15:0] a1, input logic [15:0] d1,
                       output int g);
        logic [15:0] a, d;
        bit w, inr;
        c0_req = r0; c0_we = w0; c0_addr = a0; c0_wdata = d0;
        c1_req = r1; c1_we = w1; c1_addr = a1; c1_wdata = d1;
        #1;
        if (!r0 && !r1) g = -1;
        else if (r0 != r1) g = r1 ? 1 : 0;
        else g = (m_beats < BM) ? m_owner : 1 - m_owner;
        a = (g == 1) ? a1 : a0;
        d = (g == 1) ? d1 : d0;
        w = (g == 1) ? w1 : w0;
        inr = int'(a) < DEPTH;
        chk("c0_gnt", c0_gnt, g == 0);
        chk("c1_gnt", c1_gnt, g == 1);
        chk("dm_re", dm_re, g >= 0 && inr && !w);
        chk("dm_we", dm_we, g >= 0 && inr && w);
        if (g < 0 || inr) begin
            chk("dm_addr", dm_addr, (g < 0) ? 16'h0 : a);
            chk("dm_wrt_data", dm_wrt_data, (g < 0) ? 16'h0 : d);
        end
        e_rv0 = (g == 0) && !w;
        e_rv1 = (g == 1) && !w;
        e_err = (g >= 0) && !w && !inr;
        if (g >= 0 && !w) e_rdata = inr ? shadow[a[IW-1:0]] : '0;
        if (g >= 0 && w && inr) shadow[a[IW-1:0]] = d;
        if (g < 0) m_beats = 0;
        else if (g == m_owner) m_beats = (m_beats + 1 > BM) ? BM : m_beats + 1;
        else begin
            m_owner = g;
            m_beats = 1;
        end
        @(posedge clk);
        #1;
        chk("c0_rvalid", c0_rvalid, e_rv0);
        chk("c1_rvalid", c1_rvalid, e_rv1);
        chk("rd_err", rd_err, e_err);
        chk("rdata", rdata, e_rdata);
    endtask

    task automatic idle();
        int g;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, g);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        c0_req = 1'b1; c0_addr = 16'h0011; c1_req = 1'b1; c1_we = 1'b1; c1_addr = 16'h0022; c1_wdata = 16'h3333;
        #1;
        chk("rst_c0_gnt", c0_gnt, 0);
        chk("rst_c1_gnt", c1_gnt, 0);
        chk("rst_dm_re", dm_re, 0);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_dm_addr", dm_addr, 0);
        chk("rst_dm_wrt_data", dm_wrt_data, 0);
        chk("rst_c0_rvalid", c0_rvalid, 0);
        chk("rst_c1_rvalid", c1_rvalid, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_rdata", rdata, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_c0_gnt", c0_gnt, 0);
        chk("rst_hold_rvalid", {c0_rvalid, c1_rvalid}, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int g;
        logic [11:0] pat12;
        logic [13:0] pat14;
        bit rq [2];
        bit wq [2];
        logic [15:0] aq [2];
        logic [15:0] dq [2];
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 16'(i * 7 + 1);
            shadow[i] = 16'(i * 7 + 1);
        end
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        cyc(1, 1, 5, 16'hA5A5, 0, 0, 0, 0, g);
        cyc(1, 0, 5, 0, 0, 0, 0, 0, g);
        chk("t1_c0_rvalid", c0_rvalid, 1);
        chk("t1_rdata", rdata, 16'hA5A5);
        chk("t1_c1_rvalid", c1_rvalid, 0);
        idle();

        do_reset();
        pat12 = '0;
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, 16'(10 + i), 0, 1, 0, 16'(40 + i), 0, g);
            pat12 = {pat12[10:0], g[0]};
        end
        chk("t2_pattern", pat12, 12'b0000_1111_0000);
        idle();

        pat14 = '0;
        for (int i = 0; i < 14; i++) begin
            cyc(i >= 6, 0, 16'(60 + i), 0, 1, 0, 16'(80 + i), 0, g);
            pat14 = {pat14[12:0], g[0]};
        end
        chk("t3_pattern", pat14, 14'b111111_0000_1111);
        idle();

        cyc(1, 0, 16'h0400, 0, 0, 0, 0, 0, g);
        chk("t4_rd_err", rd_err, 1);
        chk("t4_rdata", rdata, 0);
        chk("t4_c0_rvalid", c0_rvalid, 1);
        cyc(1, 1, 16'h0400, 16'hBEEF, 0, 0, 0, 0, g);
        cyc(1, 0, 16'h0000, 0, 0, 0, 0, 0, g);
        chk("t4_addr0", rdata, 16'h0001);
        chk("t4_rd_err_clr", rd_err, 0);

        cyc(1, 0, 3, 0, 0, 0, 0, 0, g);
        chk("t5_old", rdata, 16'h0016);
        cyc(0, 0, 0, 0, 1, 1, 3, 16'h1234, g);
        cyc(1, 0, 3, 0, 0, 0, 0, 0, g);
        chk("t5_new", rdata, 16'h1234);
        idle();

        cyc(1, 0, 7, 0, 0, 0, 0, 0, g);
        rst_n = 1'b0;
        #1;
        chk("t6_rvalid_drop", c0_rvalid, 0);
        chk("t6_rdata_clr", rdata, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk("t6_rvalid_after", c0_rvalid, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, g);
        cyc(1, 0, 8, 0, 1, 0, 9, 0, g);
        chk("t6_first_contended", g, 0);
        idle();

        rq[0] = 0;
        rq[1] = 0;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!rq[i] && $urandom_range(0, 3) != 0) begin
                    rq[i] = 1;
                    wq[i] = 1'($urandom_range(0, 1));
                    aq[i] = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(DEPTH, 65535)) : 16'($urandom_range(0, 31));
                    dq[i] = 16'($urandom);
                end
            end
            cyc(rq[0], wq[0], aq[0], dq[0], rq[1], wq[1], aq[1], dq[1], g);
            if (g >= 0) rq[g] = 0;
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-client arbiter that shares the single-ported data memory between the CPU load/store path (client 0) and a peripheral/DMA path (client 1). It grants at most one access per cycle, drives the memory's address, read-enable, write-enable and write-data, and returns read data to the winning client with a registered valid one cycle later. Arbitration is owner-sticky with a bounded burst length, so neither client can starve the other.

## Interface
- AW, 16: address width of client and memory ports
- DW, 16: data width
- DEPTH, 1024: memory words; addresses >= DEPTH are out of range
- BURST_MAX, 4: max consecutive grants to one client while the other is requesting
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- c0_req / c1_req  in  1  access request; held until granted
- c0_we / c1_we  in  1  1 = write, 0 = read; stable while req high
- c0_addr / c1_addr  in  AW  word address; stable while req high
- c0_wdata / c1_wdata  in  DW  write data; stable while req high
- c0_gnt / c1_gnt  out  1  combinational grant; the access happens in this cycle
- c0_rvalid / c1_rvalid  out  1  registered one-cycle pulse: read data for this client is on rdata
- rdata  out  DW  registered read data, shared by both clients and qualified by cN_rvalid
- rd_err  out  1  registered; pulses with rvalid when the returned read was out of range
- dm_addr  out  AW  memory address
- dm_re  out  1  memory read enable
- dm_we  out  1  memory write enable
- dm_wrt_data  out  DW  memory write data
- dm_rd_data  in  DW  memory read data; memory updates it on negedge of the access cycle

## Operation
- State: owner (1 bit, last granted client), beat_cnt (0..BURST_MAX, saturating), rd_pend (valid, client id, err).
- Grant rule per cycle:
  - No request: no grant.
  - Exactly one requester: grant it.
  - Both requesting: grant owner if beat_cnt < BURST_MAX, else grant the other client.
- gnt depends only on req, owner and beat_cnt. It never depends on we or addr.
- State update on posedge:
  - Grant to owner: beat_cnt <= min(beat_cnt+1, BURST_MAX).
  - Grant to non-owner: owner <= granted client, beat_cnt <= 1.
  - Idle cycle: beat_cnt <= 0, owner unchanged.
- Memory drive for a granted client g with in-range address:
  - dm_addr = cg_addr, dm_wrt_data = cg_wdata.
  - dm_re = ~cg_we, dm_we = cg_we. dm_re and dm_we are never both high.
- Out-of-range address (addr >= DEPTH):
  - The access is still granted and consumes the cycle, but dm_re = dm_we = 0.
  - A read returns rdata = 0 with rd_err = 1. A write is silently dropped.
- No grant: dm_re = dm_we = 0, dm_addr = 0, dm_wrt_data = 0.
- Read return:
  - A granted read sets rd_pend for that client.
  - At the next posedge, rdata <= dm_rd_data (or 0 if err) and cg_rvalid <= 1 for exactly one cycle.
  - rdata holds its value until the next read return.
- Writes produce no response; gnt is the completion indication.

## Timing
- Reset (rst_n low, asynchronous): owner=0, beat_cnt=0, rd_pend cleared, c0_rvalid=c1_rvalid=0, rd_err=0, rdata=0. While rst_n is low: c0_gnt=c1_gnt=0, dm_re=dm_we=0, dm_addr=0, dm_wrt_data=0.
- Reset asserted mid-access: the pending rvalid is discarded and not replayed. After release, the first contended grant goes to client 0.
- Grant latency: 0 cycles (gnt in the same cycle as req when the client wins).
- Read latency: rvalid in cycle T+1 for a read granted in cycle T. Back-to-back reads give back-to-back rvalid pulses, possibly alternating between clients.
- Throughput: one access per cycle.
- Under continuous contention the grant pattern is BURST_MAX grants to one client, then BURST_MAX to the other, and so on.
- Read in T followed by write in T+1: the rvalid/rdata for the T read are still correct, because rdata is captured at the posedge ending T.

## Test plan
- Reset, then c0 write addr 5 = 16'hA5A5, then c0 read addr 5 -> c0_gnt same cycle; c0_rvalid next cycle with rdata=16'hA5A5; c1_rvalid stays 0.
- c0 and c1 both continuously requesting reads from reset, BURST_MAX=4 -> grants c0 x4, c1 x4, c0 x4; each rvalid pulse goes to the client granted in the prior cycle.
- c1 alone for 6 cycles, then c0 joins -> c1 is owner with beat_cnt saturated at 4, so c0 wins immediately; c1 regains the grant after 4 c0 beats.
- c0 read addr 16'h0400 (out of range) -> gnt=1, dm_re=0, next cycle c0_rvalid=1, rdata=0, rd_err=1; a write to 16'h0400 leaves memory unchanged (readback of addr 0 unaffected).
- c0 read addr 3, c1 write addr 3 on consecutive cycles -> c0 gets the old value; a subsequent read of addr 3 returns the new value; dm_re and dm_we are never both high.
- Assert rst_n low in the cycle after a granted read -> rvalid=0 immediately and stays 0 after release; the first contended grant after release goes to c0.
